// File: rtl/dac_seq_pkg.sv
// Shared definitions for the DAC sample sequencer: FSM encoding, write-word
// packing and slot divider derivation.
package dac_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } seq_state_e;

  // DAC write word: the sample sits in the middle of the two data bytes.
  function automatic logic [15:0] pack_wdata(input logic [7:0] d);
    return {4'b0000, d[7:4], d[3:0], 4'b0000};
  endfunction

  function automatic logic [27:0] tick_div(input logic [27:0] sys_clk,
                                           input logic [27:0] rate);
    return sys_clk / rate;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read data; pushes while full
// are ignored even when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + AW'(1);
    if (do_pop)  rd_d = rd_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/dac_sequencer.sv
// Paces buffered 8-bit samples onto the iic_drive write path, one transfer per
// slot, with bounded retries on ack errors and underrun accounting.
module dac_sequencer
  import dac_seq_pkg::*;
#(
  parameter logic [27:0] SYS_CLK     = 28'd50_000_000,
  parameter logic [27:0] SAMPLE_RATE = 28'd1_000,
  parameter int          FIFO_DEPTH  = 4,
  parameter int          MAX_RETRY   = 2
) (
  input  logic        dac_clk,
  input  logic        dac_rst,
  input  logic        seq_en,
  input  logic [7:0]  smp_data,
  input  logic        smp_valid,
  output logic        smp_ready,
  output logic        iic_start,
  output logic        iic_rw_flag,
  output logic [15:0] iic_wdata,
  input  logic        iic_ready,
  input  logic        iic_ack_error,
  input  logic        err_clr,
  output logic        err_flag,
  output logic [7:0]  underrun_cnt,
  output logic        busy
);

  localparam logic [27:0] TICK_DIV = tick_div(SYS_CLK, SAMPLE_RATE);
  localparam int          RW       = $clog2(MAX_RETRY + 2);
  localparam int          CW       = $clog2(FIFO_DEPTH) + 1;

  seq_state_e    state_q, state_d;
  logic [27:0]   tick_cnt_q, tick_cnt_d;
  logic          tick_pend_q, tick_pend_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [15:0]   wdata_q, wdata_d;
  logic          err_q, err_d;
  logic [7:0]    under_q, under_d;

  logic          tick, slot, under_inc, pop, push;
  logic          fifo_full, fifo_empty, fifo_avail;
  logic [7:0]    fifo_rdata;
  logic [CW-1:0] fifo_cnt;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (dac_clk),
    .rst_ni  (dac_rst),
    .push_i  (push),
    .wdata_i (smp_data),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  assign push       = smp_valid && !fifo_full;
  assign smp_ready  = !fifo_full;
  assign fifo_avail = !fifo_empty && (fifo_cnt != '0);

  assign tick       = seq_en && (tick_cnt_q == TICK_DIV - 28'd1);
  assign tick_cnt_d = (!seq_en || tick) ? 28'd0 : tick_cnt_q + 28'd1;
  assign slot       = (state_q == ST_IDLE) && (tick || (tick_pend_q && seq_en));

  always_comb begin
    state_d     = state_q;
    retry_d     = retry_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    tick_pend_d = tick_pend_q;
    under_inc   = 1'b0;
    pop         = 1'b0;
    iic_start   = 1'b0;
    if (err_clr) err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (slot) begin
          // a fresh tick coinciding with a served pending slot stays pending
          tick_pend_d = tick && tick_pend_q;
          if (fifo_avail) begin
            pop     = 1'b1;
            wdata_d = pack_wdata(fifo_rdata);
            retry_d = '0;
            state_d = ST_ISSUE;
          end else begin
            under_inc = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        if (iic_ready) begin
          iic_start = 1'b1;
          state_d   = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: begin
        if (!iic_ready) state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (iic_ready) begin
          if (!iic_ack_error) begin
            state_d = ST_IDLE;
          end else if (int'(retry_q) < MAX_RETRY) begin
            retry_d = retry_q + RW'(1);
            state_d = ST_ISSUE;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if ((state_q != ST_IDLE) && tick) begin
      if (tick_pend_q) under_inc = 1'b1;
      tick_pend_d = 1'b1;
    end
    if (!seq_en) tick_pend_d = 1'b0;
  end

  assign under_d = (under_inc && (under_q != 8'hFF)) ? under_q + 8'd1 : under_q;

  always_ff @(posedge dac_clk or negedge dac_rst) begin
    if (!dac_rst) begin
      state_q     <= ST_IDLE;
      tick_cnt_q  <= '0;
      tick_pend_q <= 1'b0;
      retry_q     <= '0;
      wdata_q     <= '0;
      err_q       <= 1'b0;
      under_q     <= '0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      tick_pend_q <= tick_pend_d;
      retry_q     <= retry_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      under_q     <= under_d;
    end
  end

  assign iic_rw_flag  = 1'b0;
  assign iic_wdata    = wdata_q;
  assign err_flag     = err_q;
  assign underrun_cnt = under_q;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dac_sequencer.sv
// Directed and randomized bench for dac_sequencer with a behavioural iic_drive
// model (20 busy cycles per start, scripted ack errors).
module tb_dac_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        seq_en = 1'b0;
  logic [7:0]  smp_data = '0;
  logic        smp_valid = 1'b0;
  logic        smp_ready;
  logic        iic_start;
  logic        iic_rw_flag;
  logic [15:0] iic_wdata;
  logic        iic_ready;
  logic        iic_ack_error;
  logic        err_clr = 1'b0;
  logic        err_flag;
  logic [7:0]  underrun_cnt;
  logic        busy;
  logic        hold_busy = 1'b0;

  int checks = 0;
  int errors = 0;

  dac_sequencer #(
    .SYS_CLK(28'd1000), .SAMPLE_RATE(28'd10), .FIFO_DEPTH(4), .MAX_RETRY(2)
  ) dut (
    .dac_clk(clk), .dac_rst(rst_n), .seq_en(seq_en), .smp_data(smp_data),
    .smp_valid(smp_valid), .smp_ready(smp_ready), .iic_start(iic_start),
    .iic_rw_flag(iic_rw_flag), .iic_wdata(iic_wdata), .iic_ready(iic_ready),
    .iic_ack_error(iic_ack_error), .err_clr(err_clr), .err_flag(err_flag),
    .underrun_cnt(underrun_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  // Driver model: busy for 20 cycles after a start, then reports the next planned ack.
  logic mdl_rdy, mdl_ack;
  int   mdl_cnt;
  bit   ack_plan[$];
  assign iic_ready     = mdl_rdy && !hold_busy;
  assign iic_ack_error = mdl_ack;

  always @(posedge clk or negedge rst_n) begin
    bit a;
    if (!rst_n) begin
      mdl_rdy <= 1'b1; mdl_ack <= 1'b0; mdl_cnt <= 0;
    end else if (iic_start) begin
      mdl_rdy <= 1'b0; mdl_ack <= 1'b0; mdl_cnt <= 20;
    end else if (mdl_cnt > 0) begin
      mdl_cnt <= mdl_cnt - 1;
      if (mdl_cnt == 1) begin
        a = (ack_plan.size() > 0) ? ack_plan.pop_front() : 1'b0;
        mdl_rdy <= 1'b1;
        mdl_ack <= a;
      end
    end
  end

  typedef struct { int c; logic [15:0] w; } srec_t;
  srec_t slog[$];
  int    cyc = 0;
  int    viol = 0;
  bit    prev_start = 1'b0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (iic_start === 1'b1) begin
      if (prev_start || iic_ready !== 1'b1) viol = viol + 1;
      slog.push_back('{cyc, iic_wdata});
    end
    prev_start = (iic_start === 1'b1);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; seq_en = 1'b0; smp_valid = 1'b0; err_clr = 1'b0; hold_busy = 1'b0;
    ack_plan.delete();
    step(2);
    chk("rst_start", 32'(iic_start), 32'd0);
    chk("rst_wdata", 32'(iic_wdata), 32'd0);
    chk("rst_err",   32'(err_flag), 32'd0);
    chk("rst_under", 32'(underrun_cnt), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_ready", 32'(smp_ready), 32'd1);
    chk("rst_rw",    32'(iic_rw_flag), 32'd0);
    rst_n = 1'b1;
    step(1);
    slog.delete();
  endtask

  task automatic push(input logic [7:0] d);
    smp_valid = 1'b1; smp_data = d;
    step(1);
    smp_valid = 1'b0;
  endtask

  task automatic wait_starts(input string tag, input int n, input int budget);
    int k = 0;
    while (slog.size() < n && k < budget) begin step(1); k++; end
    chk(tag, 32'(slog.size()), 32'(n));
  endtask

  initial begin
    int c0;
    logic [7:0] d;
    int e, n, att, nexp;
    bit exp_err;
    logic [15:0] exp_w[$];

    // basic write
    do_reset();
    push(8'h7A);
    seq_en = 1'b1; c0 = cyc;
    wait_starts("basic_start", 1, 150);
    if (slog.size() >= 1) begin
      chk("basic_lat", 32'(slog[0].c - c0 - 1), 32'd100);
      chk("basic_w",   32'(slog[0].w), 32'h07A0);
    end
    chk("basic_busy_hi", 32'(busy), 32'd1);
    step(30); seq_en = 1'b0;
    chk("basic_busy_lo", 32'(busy), 32'd0);
    chk("basic_under",   32'(underrun_cnt), 32'd0);

    // FIFO full: fifth push refused
    do_reset();
    for (int i = 0; i < 5; i++) begin
      smp_valid = 1'b1; smp_data = 8'h10 + 8'(i);
      #1 chk("full_ready", 32'(smp_ready), (i < 4) ? 32'd1 : 32'd0);
      step(1);
    end
    smp_valid = 1'b0;
    seq_en = 1'b1;
    wait_starts("full_starts", 4, 500);
    step(30); seq_en = 1'b0;
    chk("full_count", 32'(slog.size()), 32'd4);
    for (int i = 0; i < 4 && i < slog.size(); i++) begin
      chk("full_w", 32'(slog[i].w), 32'h0100 + 32'(i) * 32'h10);
      if (i > 0) chk("full_gap", 32'(slog[i].c - slog[i-1].c), 32'd100);
    end
    chk("full_under", 32'(underrun_cnt), 32'd0);

    // underrun with empty FIFO
    do_reset();
    seq_en = 1'b1; step(350); seq_en = 1'b0;
    chk("ur_starts", 32'(slog.size()), 32'd0);
    chk("ur_cnt",    32'(underrun_cnt), 32'd3);

    // two ack errors then success
    do_reset();
    ack_plan.push_back(1'b1); ack_plan.push_back(1'b1);
    push(8'h55);
    seq_en = 1'b1;
    wait_starts("rt_starts", 3, 250);
    step(30); seq_en = 1'b0;
    chk("rt_count", 32'(slog.size()), 32'd3);
    for (int i = 0; i < slog.size(); i++) begin
      chk("rt_w", 32'(slog[i].w), 32'h0550);
      if (i > 0) chk("rt_gap", 32'(slog[i].c - slog[i-1].c), 32'd22);
    end
    chk("rt_err", 32'(err_flag), 32'd0);

    // retries exhausted
    do_reset();
    for (int i = 0; i < 4; i++) ack_plan.push_back(1'b1);
    push(8'h3C);
    seq_en = 1'b1;
    wait_starts("rx_first", 1, 150);
    step(80); seq_en = 1'b0;
    chk("rx_count", 32'(slog.size()), 32'd3);
    chk("rx_err",   32'(err_flag), 32'd1);
    step(5);
    chk("rx_err_hold", 32'(err_flag), 32'd1);
    err_clr = 1'b1; step(1); err_clr = 1'b0;
    chk("rx_err_clr", 32'(err_flag), 32'd0);

    // busy driver: one slot pending, one collapsed
    do_reset();
    push(8'hA1); push(8'hA2);
    hold_busy = 1'b1; seq_en = 1'b1;
    step(320);
    chk("bz_nostart", 32'(slog.size()), 32'd0);
    chk("bz_busy",    32'(busy), 32'd1);
    hold_busy = 1'b0;
    wait_starts("bz_starts", 2, 60);
    step(10); seq_en = 1'b0;
    if (slog.size() >= 2) begin
      chk("bz_w0",  32'(slog[0].w), 32'h0A10);
      chk("bz_w1",  32'(slog[1].w), 32'h0A20);
      chk("bz_gap", 32'(slog[1].c - slog[0].c), 32'd23);
    end
    chk("bz_under", 32'(underrun_cnt), 32'd1);

    // reset while waiting for transfer completion
    do_reset();
    push(8'h11); push(8'h22);
    seq_en = 1'b1;
    wait_starts("mr_start", 1, 150);
    step(5);
    chk("mr_busy", 32'(busy), 32'd1);
    seq_en = 1'b0; rst_n = 1'b0;
    #1;
    chk("mr_start0", 32'(iic_start), 32'd0);
    chk("mr_busy0",  32'(busy), 32'd0);
    chk("mr_wdata0", 32'(iic_wdata), 32'd0);
    chk("mr_ready1", 32'(smp_ready), 32'd1);
    step(2); rst_n = 1'b1; step(1);
    slog.delete();
    seq_en = 1'b1; step(120); seq_en = 1'b0;
    chk("mr_empty", 32'(slog.size()), 32'd0);
    chk("mr_under", 32'(underrun_cnt), 32'd1);

    // randomized samples and ack-error patterns against a transaction-level model
    for (int it = 0; it < 6; it++) begin
      do_reset();
      exp_w.delete(); exp_err = 1'b0;
      n = $urandom_range(1, 4);
      for (int s = 0; s < n; s++) begin
        d = 8'($urandom);
        e = $urandom_range(0, 3);
        att = (e >= 3) ? 3 : e + 1;
        if (e >= 3) exp_err = 1'b1;
        for (int k = 0; k < att; k++) begin
          ack_plan.push_back(k < e);
          exp_w.push_back(16'(d) * 16'd16);
        end
        push(d);
      end
      nexp = exp_w.size();
      seq_en = 1'b1;
      wait_starts("rnd_starts", nexp, n * 100 + 200);
      step(40); seq_en = 1'b0;
      chk("rnd_count", 32'(slog.size()), 32'(nexp));
      for (int i = 0; i < nexp && i < slog.size(); i++)
        chk("rnd_w", 32'(slog[i].w), 32'(exp_w[i]));
      chk("rnd_err",   32'(err_flag), 32'(exp_err));
      chk("rnd_under", 32'(underrun_cnt), 32'd0);
    end

    chk("start_pulse_rules", 32'(viol), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
